// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the program-run sequencer.
package run_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } run_state_t;

  localparam int unsigned DEF_MAX_PROGS = 4;
  localparam int unsigned DEF_START_LEN = 2;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_TIMEOUT   = 32'h0000_FFFF;

endpackage

// File: rtl/run_result_buf.sv
// Per-run result store: cycle count plus timeout flag, one write port,
// one registered read port, synchronous clear of every entry.
module run_result_buf #(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [CNT_W-1:0]  WrCount,
  input  logic              WrTimeout,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [CNT_W-1:0]  RdCount,
  output logic              RdTimeout
);

  logic [CNT_W-1:0] countMem [DEPTH];
  logic [DEPTH-1:0] flagMem;

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        countMem[i] <= '0;
      end
      flagMem <= '0;
    end else if (WrEn && (32'(WrAddr) < DEPTH)) begin
      countMem[WrAddr] <= WrCount;
      flagMem[WrAddr]  <= WrTimeout;
    end
  end

  // Reads see the array before this edge's write or clear lands.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RdCount   <= '0;
      RdTimeout <= 1'b0;
    end else if (32'(RdAddr) < DEPTH) begin
      RdCount   <= countMem[RdAddr];
      RdTimeout <= flagMem[RdAddr];
    end else begin
      RdCount   <= '0;
      RdTimeout <= 1'b0;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Drives the processor Start/Ack handshake for up to MAX_PROGS back-to-back
// runs per Go, timing each run and logging counts/timeouts to a result buffer.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter  int unsigned MAX_PROGS = DEF_MAX_PROGS,
  parameter  int unsigned START_LEN = DEF_START_LEN,
  parameter  int unsigned CNT_W     = DEF_CNT_W,
  parameter  int unsigned TIMEOUT   = DEF_TIMEOUT,
  localparam int unsigned NUM_W     = $clog2(MAX_PROGS + 1),
  localparam int unsigned IDX_W     = (MAX_PROGS > 1) ? $clog2(MAX_PROGS) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic [NUM_W-1:0] NumProgs,
  input  logic             DutAck,
  output logic             DutStart,
  output logic             Busy,
  output logic             Done,
  output logic [IDX_W-1:0] ProgIdx,
  input  logic [IDX_W-1:0] RdAddr,
  output logic [CNT_W-1:0] RdCount,
  output logic             RdTimeout
);

  localparam int unsigned START_W = $clog2(START_LEN + 1);
  localparam logic [CNT_W:0] TIMEOUT_X = (CNT_W + 1)'(TIMEOUT);

  run_state_t         state;
  logic [NUM_W-1:0]   numLatched;
  logic [NUM_W-1:0]   numClamped;
  logic [CNT_W-1:0]   cycleCnt;
  logic [CNT_W:0]     cntNext;
  logic [START_W-1:0] startCnt;
  logic               goAccept;
  logic               ackSeen;
  logic               timeoutHit;
  logic               runEnd;
  logic               lastProg;
  logic [CNT_W-1:0]   wrCount;

  always_comb begin
    cntNext    = {1'b0, cycleCnt} + (CNT_W + 1)'(1);
    goAccept   = Go && ((state == ST_IDLE) || (state == ST_DONE));
    numClamped = (32'(NumProgs) > MAX_PROGS) ? NUM_W'(MAX_PROGS) : NumProgs;
    ackSeen    = (state == ST_RUN) && DutAck;
    // A real Ack on the last permitted cycle wins over the timeout flag.
    timeoutHit = ((state == ST_ARM) || (state == ST_RUN)) && !ackSeen &&
                 (cntNext >= TIMEOUT_X);
    runEnd     = ackSeen || timeoutHit;
    lastProg   = (NUM_W'(ProgIdx) == (numLatched - NUM_W'(1)));
    wrCount    = timeoutHit ? TIMEOUT_X[CNT_W-1:0] : cntNext[CNT_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      DutStart   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      ProgIdx    <= '0;
      numLatched <= '0;
      cycleCnt   <= '0;
      startCnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (goAccept) begin
            numLatched <= numClamped;
            ProgIdx    <= '0;
            if (numClamped == '0) begin
              state    <= ST_DONE;
              Done     <= 1'b1;
              Busy     <= 1'b0;
              DutStart <= 1'b0;
            end else begin
              state    <= ST_START;
              Done     <= 1'b0;
              Busy     <= 1'b1;
              DutStart <= 1'b1;
              startCnt <= '0;
            end
          end
        end
        ST_START: begin
          if (startCnt == START_W'(START_LEN - 1)) begin
            state    <= ST_ARM;
            DutStart <= 1'b0;
            cycleCnt <= '0;
          end else begin
            startCnt <= startCnt + START_W'(1);
          end
        end
        ST_ARM, ST_RUN: begin
          if (runEnd) begin
            if (lastProg) begin
              state <= ST_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              ProgIdx  <= ProgIdx + IDX_W'(1);
              state    <= ST_START;
              DutStart <= 1'b1;
              startCnt <= '0;
            end
          end else begin
            if ((state == ST_ARM) && !DutAck) begin
              state <= ST_RUN;
            end
            if (!cntNext[CNT_W]) begin
              cycleCnt <= cntNext[CNT_W-1:0];
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          DutStart <= 1'b0;
          Busy     <= 1'b0;
          Done     <= 1'b0;
        end
      endcase
    end
  end

  run_result_buf #(
    .DEPTH (MAX_PROGS),
    .CNT_W (CNT_W)
  ) u_buf (
    .Clk       (Clk),
    .Reset     (Reset),
    .Clear     (goAccept),
    .WrEn      (runEnd),
    .WrAddr    (ProgIdx),
    .WrCount   (wrCount),
    .WrTimeout (timeoutHit),
    .RdAddr    (RdAddr),
    .RdCount   (RdCount),
    .RdTimeout (RdTimeout)
  );

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: expected buffer entries are queued as each
// run is driven and popped when the buffer is read back.
module tb_run_sequencer;

  localparam int unsigned MAXP = 4;
  localparam int unsigned TO   = 20;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Go;
  logic [2:0]  NumProgs;
  logic        DutAck;
  logic        DutStart;
  logic        Busy;
  logic        Done;
  logic [1:0]  ProgIdx;
  logic [1:0]  RdAddr;
  logic [15:0] RdCount;
  logic        RdTimeout;

  typedef struct packed {
    logic [15:0] cnt;
    logic        to;
  } entry_t;

  entry_t sb[$];
  int nChecks = 0;
  int nFails  = 0;

  run_sequencer #(
    .MAX_PROGS (MAXP),
    .START_LEN (2),
    .CNT_W     (16),
    .TIMEOUT   (TO)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Go        (Go),
    .NumProgs  (NumProgs),
    .DutAck    (DutAck),
    .DutStart  (DutStart),
    .Busy      (Busy),
    .Done      (Done),
    .ProgIdx   (ProgIdx),
    .RdAddr    (RdAddr),
    .RdCount   (RdCount),
    .RdTimeout (RdTimeout)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry: negedge of the first START cycle. Ack high for hi ARM cycles, low
  // for lo cycles, then high; stored count is hi + lo + 1.
  task automatic runProg(input int hi, input int lo, input int idx);
    entry_t e;
    check("progIdx", 32'(ProgIdx), 32'(idx));
    check("busyRun", 32'(Busy), 32'd1);
    step();
    check("startHi2", 32'(DutStart), 32'd1);
    step();
    check("startLen", 32'(DutStart), 32'd0);
    for (int i = 0; i < hi; i++) begin
      DutAck = 1'b1;
      step();
    end
    for (int i = 0; i < lo; i++) begin
      DutAck = 1'b0;
      step();
    end
    DutAck = 1'b1;
    e.cnt = 16'(hi + lo + 1);
    e.to  = 1'b0;
    sb.push_back(e);
    step();
  endtask

  // Ack held at one level for the whole run; the run must time out.
  task automatic runStuck(input logic level, input int idx, input bit pulseGo);
    entry_t e;
    check("progIdxTo", 32'(ProgIdx), 32'(idx));
    step();
    step();
    check("startLenTo", 32'(DutStart), 32'd0);
    for (int k = 0; k < int'(TO); k++) begin
      DutAck   = level;
      Go       = (pulseGo && k == 0);
      NumProgs = (pulseGo && k == 0) ? 3'd1 : 3'd2;
      step();
    end
    Go = 1'b0;
    e.cnt = 16'(TO);
    e.to  = 1'b1;
    sb.push_back(e);
  endtask

  task automatic readBack(input string tag);
    entry_t e;
    for (int a = 0; a < int'(MAXP); a++) begin
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      RdAddr = 2'(a);
      step();
      check({tag, "_cnt"}, 32'(RdCount), 32'(e.cnt));
      check({tag, "_to"}, 32'(RdTimeout), 32'(e.to));
    end
  endtask

  task automatic pulseGo(input logic [2:0] n);
    NumProgs = n;
    Go = 1'b1;
    step();
    Go = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; NumProgs = '0; DutAck = 1'b0; RdAddr = '0;
    step(); step(); step();
    check("rstStart", 32'(DutStart), 32'd0);
    check("rstBusy", 32'(Busy), 32'd0);
    check("rstDone", 32'(Done), 32'd0);
    check("rstIdx", 32'(ProgIdx), 32'd0);
    check("rstRdCnt", 32'(RdCount), 32'd0);
    check("rstRdTo", 32'(RdTimeout), 32'd0);
    Reset = 1'b0;
    step();

    // Single run, Ack still high from a previous halt.
    DutAck = 1'b1;
    pulseGo(3'd1);
    check("startRise", 32'(DutStart), 32'd1);
    runProg(2, 5, 0);
    check("done1", 32'(Done), 32'd1);
    check("idle1Busy", 32'(Busy), 32'd0);
    check("done1Start", 32'(DutStart), 32'd0);
    readBack("t1");

    // Three back-to-back runs restarted from DONE.
    pulseGo(3'd3);
    runProg(0, 4, 0);
    check("noGap0", 32'(DutStart), 32'd1);
    runProg(0, 10, 1);
    check("noGap1", 32'(DutStart), 32'd1);
    runProg(0, 1, 2);
    check("done2", 32'(Done), 32'd1);
    readBack("t2");

    // Timeouts: Ack stuck low then stuck high; Go pulsed while Busy is ignored.
    pulseGo(3'd2);
    runStuck(1'b0, 0, 1'b1);
    check("toNext", 32'(DutStart), 32'd1);
    check("toNotDone", 32'(Done), 32'd0);
    runStuck(1'b1, 1, 1'b0);
    check("done3", 32'(Done), 32'd1);
    readBack("t3");

    // Zero runs: straight to DONE with the buffer cleared.
    DutAck = 1'b1;
    pulseGo(3'd0);
    check("zeroDone", 32'(Done), 32'd1);
    check("zeroStart", 32'(DutStart), 32'd0);
    check("zeroBusy", 32'(Busy), 32'd0);
    step();
    check("zeroStart2", 32'(DutStart), 32'd0);
    readBack("t4");

    // Request above MAX_PROGS is clamped to four runs.
    pulseGo(3'd7);
    runProg(1, 2, 0);
    runProg(0, 5, 1);
    runProg(3, 1, 2);
    runProg(0, 2, 3);
    check("clampDone", 32'(Done), 32'd1);
    check("clampStart", 32'(DutStart), 32'd0);
    readBack("t5");

    // Reset in the middle of run 1 discards everything.
    pulseGo(3'd2);
    runProg(0, 3, 0);
    check("rIdx1", 32'(ProgIdx), 32'd1);
    step();
    step();
    DutAck = 1'b0;
    step();
    step();
    RdAddr = 2'd0;
    Reset = 1'b1;
    step();
    check("midRstStart", 32'(DutStart), 32'd0);
    check("midRstBusy", 32'(Busy), 32'd0);
    check("midRstDone", 32'(Done), 32'd0);
    check("midRstIdx", 32'(ProgIdx), 32'd0);
    check("midRstRd", 32'(RdCount), 32'd0);
    Reset = 1'b0;
    sb.delete();
    readBack("t6");

    // Recovery after reset.
    pulseGo(3'd1);
    runProg(0, 1, 0);
    check("recDone", 32'(Done), 32'd1);
    readBack("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
